// File: rtl/rr_reg_arbiter_pkg.sv
`timescale 1ns/1ps
`default_nettype none
// rr_reg_arbiter_pkg: shared types and constants for the round-robin register arbiter.
package rr_reg_arbiter_pkg;

    localparam int NREQ_MAX       = 8;
    localparam int TIMEOUT_CYCLES = 8;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_GRANT   = 2'd1,
        ST_RELEASE = 2'd2
    } state_e;

    // The pointer resets to the top requester so the scan starts at requester 0.
    function automatic int reset_ptr(input int nreq);
        return nreq - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/rr_reg_arbiter_pick.sv
`timescale 1ns/1ps
`default_nettype none
// rr_pick: combinational rotate-priority encoder; first set req scanning up from ptr+1, wrapping.
module rr_pick
    import rr_reg_arbiter_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDXW = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IDXW-1:0] ptr_i,
    output logic            found_o,
    output logic [IDXW-1:0] idx_o
);

    localparam int SW = IDXW + 1;

    logic [SW-1:0]     base;
    logic [SW-1:0]     sum;
    logic [2*NREQ-1:0] dbl;
    logic [NREQ-1:0]   rot;

    always_comb begin
        found_o = 1'b0;
        idx_o   = '0;
        sum     = '0;
        base    = {1'b0, ptr_i} + 1'b1;
        // Bit j of rot is req[(ptr+1+j) mod NREQ]; the lowest set bit wins.
        dbl     = {req_i, req_i} >> base;
        rot     = dbl[NREQ-1:0];
        for (int j = 0; j < NREQ; j++) begin
            if (!found_o && rot[j]) begin
                found_o = 1'b1;
                sum     = base + SW'(j);
                if (sum >= SW'(NREQ)) begin
                    sum = sum - SW'(NREQ);
                end
                idx_o   = sum[IDXW-1:0];
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/rr_reg_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// rr_reg_arbiter: round-robin arbiter committing one requester's data to a shared register.
// Optional macro ARB_TIMEOUT_EN adds a RELEASE timeout, per-requester block mask and timeout_err.
module rr_reg_arbiter
    import rr_reg_arbiter_pkg::*;
#(
    parameter int NREQ  = 4,
    parameter int WIDTH = 4,
    parameter int IDXW  = $clog2(NREQ)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [NREQ-1:0]       req,
    input  logic [NREQ*WIDTH-1:0] wdata,
    output logic [NREQ-1:0]       gnt,
    output logic [WIDTH-1:0]      q,
    output logic                  wr_done,
    output logic [IDXW-1:0]       winner,
`ifdef ARB_TIMEOUT_EN
    output logic                  busy,
    output logic                  timeout_err
`else
    output logic                  busy
`endif
);

    localparam logic [IDXW-1:0] PTR_RST = IDXW'(reset_ptr(NREQ));

    state_e            state_q, state_d;
    logic [NREQ-1:0]   gnt_q, gnt_d;
    logic [WIDTH-1:0]  q_q, q_d;
    logic              wr_done_q, wr_done_d;
    logic [IDXW-1:0]   winner_q, winner_d;
    logic [IDXW-1:0]   ptr_q, ptr_d;
    logic              busy_q;
    logic [WIDTH-1:0]  wsel;
    logic [NREQ-1:0]   pick_req;
    logic              pick_found;
    logic [IDXW-1:0]   pick_idx;

`ifdef ARB_TIMEOUT_EN
    logic [3:0]        tmo_cnt_q, tmo_cnt_d;
    logic [NREQ-1:0]   blk_q, blk_d;
    logic              tmo_err_q, tmo_err_d;

    assign pick_req = req & ~blk_q;
`else
    assign pick_req = req;
`endif

    rr_pick #(
        .NREQ (NREQ),
        .IDXW (IDXW)
    ) u_pick (
        .req_i   (pick_req),
        .ptr_i   (ptr_q),
        .found_o (pick_found),
        .idx_o   (pick_idx)
    );

    always_comb begin
        wsel = '0;
        for (int i = 0; i < NREQ; i++) begin
            if (winner_q == IDXW'(i)) begin
                wsel = wdata[i*WIDTH +: WIDTH];
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt_q;
        q_d       = q_q;
        wr_done_d = 1'b0;
        winner_d  = winner_q;
        ptr_d     = ptr_q;
`ifdef ARB_TIMEOUT_EN
        tmo_cnt_d = tmo_cnt_q;
        tmo_err_d = tmo_err_q;
        // A blocked requester is released once its req has been seen low.
        blk_d     = blk_q & req;
`endif
        case (state_q)
            ST_IDLE: begin
                gnt_d = '0;
                if (pick_found) begin
                    gnt_d[pick_idx] = 1'b1;
                    winner_d        = pick_idx;
                    state_d         = ST_GRANT;
                end
            end
            ST_GRANT: begin
                gnt_d = '0;
                if (req[winner_q]) begin
                    q_d       = wsel;
                    wr_done_d = 1'b1;
                    ptr_d     = winner_q;
                    state_d   = ST_RELEASE;
`ifdef ARB_TIMEOUT_EN
                    tmo_cnt_d = '0;
`endif
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_RELEASE: begin
                if (!req[winner_q]) begin
                    state_d = ST_IDLE;
                end
`ifdef ARB_TIMEOUT_EN
                else if (tmo_cnt_q == 4'(TIMEOUT_CYCLES - 1)) begin
                    state_d         = ST_IDLE;
                    tmo_err_d       = 1'b1;
                    blk_d[winner_q] = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 4'd1;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
                gnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            gnt_q     <= '0;
            q_q       <= '0;
            wr_done_q <= 1'b0;
            winner_q  <= '0;
            ptr_q     <= PTR_RST;
            busy_q    <= 1'b0;
`ifdef ARB_TIMEOUT_EN
            tmo_cnt_q <= '0;
            blk_q     <= '0;
            tmo_err_q <= 1'b0;
`endif
        end else begin
            state_q   <= state_d;
            gnt_q     <= gnt_d;
            q_q       <= q_d;
            wr_done_q <= wr_done_d;
            winner_q  <= winner_d;
            ptr_q     <= ptr_d;
            busy_q    <= (state_d != ST_IDLE);
`ifdef ARB_TIMEOUT_EN
            tmo_cnt_q <= tmo_cnt_d;
            blk_q     <= blk_d;
            tmo_err_q <= tmo_err_d;
`endif
        end
    end

    assign gnt     = gnt_q;
    assign q       = q_q;
    assign wr_done = wr_done_q;
    assign winner  = winner_q;
    assign busy    = busy_q;
`ifdef ARB_TIMEOUT_EN
    assign timeout_err = tmo_err_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_rr_reg_arbiter.sv
`timescale 1ns/1ps
`default_nettype none
// tb_rr_reg_arbiter: vector table, hand sequences and randomized run against a transaction-level model.
module tb_rr_reg_arbiter;

    localparam int N = 4;

    logic        clk;
    logic        reset;
    logic [3:0]  req;
    logic [15:0] wdata;
    logic [3:0]  gnt;
    logic [3:0]  q;
    logic        wr_done;
    logic [1:0]  winner;
    logic        busy;
`ifdef ARB_TIMEOUT_EN
    logic        timeout_err;
`endif

    int checks   = 0;
    int failures = 0;

    rr_reg_arbiter #(.NREQ(4), .WIDTH(4)) dut (
        .clk         (clk),
        .reset       (reset),
        .req         (req),
        .wdata       (wdata),
        .gnt         (gnt),
        .q           (q),
        .wr_done     (wr_done),
        .winner      (winner),
`ifdef ARB_TIMEOUT_EN
        .busy        (busy),
        .timeout_err (timeout_err)
`else
        .busy        (busy)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    typedef struct {
        logic        rst;
        logic [3:0]  rq;
        logic [15:0] wd;
        logic [3:0]  e_gnt;
        logic [3:0]  e_q;
        logic        e_wr;
        logic [1:0]  e_win;
        logic        e_busy;
    } vec_t;

    vec_t vq[$];

    task automatic addv(input logic r, input logic [3:0] rq, input logic [15:0] wd,
                        input logic [3:0] g, input logic [3:0] qq, input logic wr,
                        input logic [1:0] win, input logic b);
        vec_t v;
        v.rst = r; v.rq = rq; v.wd = wd; v.e_gnt = g; v.e_q = qq;
        v.e_wr = wr; v.e_win = win; v.e_busy = b;
        vq.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [11:0] outs();
        return {gnt, q, wr_done, winner, busy};
    endfunction

    // Transaction-level reference: owner=-1 means nobody holds the register.
    int          m_owner, m_last, m_hold;
    bit          m_wrote, m_wr, m_busy, m_err;
    logic [3:0]  m_gnt, m_q, m_blk;
    int          m_win;

    task automatic model_step(input logic r, input logic [3:0] rq, input logic [15:0] wd);
        logic [3:0] elig;
        m_wr = 1'b0;
        if (r) begin
            m_owner = -1; m_last = N - 1; m_gnt = 0; m_q = 0; m_win = 0;
            m_busy = 0; m_err = 0; m_blk = 0; m_wrote = 0; m_hold = 0;
            return;
        end
        elig = rq;
`ifdef ARB_TIMEOUT_EN
        elig  = rq & ~m_blk;
        m_blk = m_blk & rq;
`endif
        if (m_owner < 0) begin
            m_gnt = 0;
            for (int k = 1; k <= N; k++) begin
                int c;
                c = (m_last + k) % N;
                if (elig[c]) begin
                    m_owner = c; m_wrote = 0; m_gnt = 4'(1 << c); m_win = c;
                    break;
                end
            end
        end else if (!m_wrote) begin
            m_gnt = 0;
            if (rq[m_owner]) begin
                m_q = wd[m_owner*4 +: 4]; m_wr = 1; m_last = m_owner;
                m_wrote = 1; m_hold = 0;
            end else begin
                m_owner = -1;
            end
        end else begin
            if (!rq[m_owner]) begin
                m_owner = -1;
            end
`ifdef ARB_TIMEOUT_EN
            else begin
                m_hold++;
                if (m_hold == 8) begin
                    m_blk[m_owner] = 1'b1; m_err = 1; m_owner = -1;
                end
            end
`endif
        end
        m_busy = (m_owner >= 0);
    endtask

    initial begin
        int n_wr;
        int tmo_at;
        bit gnt_seen;
        logic r;

        reset = 1'b1; req = '0; wdata = '0;

        // Reset, single write, full contention, abort + pointer hold, reset mid-GRANT.
        addv(1, 4'hF, 16'h0000, 4'h0, 4'h0, 0, 2'd0, 0);
        addv(1, 4'hF, 16'h0000, 4'h0, 4'h0, 0, 2'd0, 0);
        addv(0, 4'h4, 16'h0A00, 4'h4, 4'h0, 0, 2'd2, 1);
        addv(0, 4'h4, 16'h0A00, 4'h0, 4'hA, 1, 2'd2, 1);
        addv(0, 4'h0, 16'h0A00, 4'h0, 4'hA, 0, 2'd2, 0);
        addv(1, 4'h0, 16'h4321, 4'h0, 4'h0, 0, 2'd0, 0);
        addv(0, 4'hF, 16'h4321, 4'h1, 4'h0, 0, 2'd0, 1);
        addv(0, 4'hF, 16'h4321, 4'h0, 4'h1, 1, 2'd0, 1);
        addv(0, 4'hE, 16'h4321, 4'h0, 4'h1, 0, 2'd0, 0);
        addv(0, 4'hE, 16'h4321, 4'h2, 4'h1, 0, 2'd1, 1);
        addv(0, 4'hE, 16'h4321, 4'h0, 4'h2, 1, 2'd1, 1);
        addv(0, 4'hC, 16'h4321, 4'h0, 4'h2, 0, 2'd1, 0);
        addv(0, 4'hC, 16'h4321, 4'h4, 4'h2, 0, 2'd2, 1);
        addv(0, 4'hC, 16'h4321, 4'h0, 4'h3, 1, 2'd2, 1);
        addv(0, 4'h8, 16'h4321, 4'h0, 4'h3, 0, 2'd2, 0);
        addv(0, 4'h8, 16'h4321, 4'h8, 4'h3, 0, 2'd3, 1);
        addv(0, 4'h8, 16'h4321, 4'h0, 4'h4, 1, 2'd3, 1);
        addv(0, 4'h0, 16'h4321, 4'h0, 4'h4, 0, 2'd3, 0);
        addv(0, 4'h1, 16'h0005, 4'h1, 4'h4, 0, 2'd0, 1);
        addv(0, 4'h1, 16'h0005, 4'h0, 4'h5, 1, 2'd0, 1);
        addv(0, 4'h0, 16'h0005, 4'h0, 4'h5, 0, 2'd0, 0);
        addv(0, 4'h2, 16'h0060, 4'h2, 4'h5, 0, 2'd1, 1);
        addv(0, 4'h0, 16'h0060, 4'h0, 4'h5, 0, 2'd1, 0);
        addv(0, 4'h3, 16'h0078, 4'h2, 4'h5, 0, 2'd1, 1);
        addv(0, 4'h3, 16'h0078, 4'h0, 4'h7, 1, 2'd1, 1);
        addv(0, 4'h1, 16'h0078, 4'h0, 4'h7, 0, 2'd1, 0);
        addv(0, 4'h1, 16'h0078, 4'h1, 4'h7, 0, 2'd0, 1);
        addv(0, 4'h1, 16'h0078, 4'h0, 4'h8, 1, 2'd0, 1);
        addv(0, 4'h0, 16'h0078, 4'h0, 4'h8, 0, 2'd0, 0);
        addv(0, 4'h4, 16'h0700, 4'h4, 4'h8, 0, 2'd2, 1);
        addv(1, 4'h4, 16'h0700, 4'h0, 4'h0, 0, 2'd0, 0);
        addv(0, 4'h0, 16'h0700, 4'h0, 4'h0, 0, 2'd0, 0);

        for (int i = 0; i < vq.size(); i++) begin
            reset = vq[i].rst; req = vq[i].rq; wdata = vq[i].wd;
            tick();
            chk($sformatf("vec%0d{gnt,q,wr,win,busy}", i), 32'(outs()),
                32'({vq[i].e_gnt, vq[i].e_q, vq[i].e_wr, vq[i].e_win, vq[i].e_busy}));
        end
`ifdef ARB_TIMEOUT_EN
        chk("vec_timeout_err", 32'(timeout_err), 32'd0);

        // Permanently held req[3] times out after 8 RELEASE cycles and is then blocked.
        reset = 1'b1; req = 4'h0; tick();
        reset = 1'b0; req = 4'h8; wdata = 16'h9000;
        n_wr = 0; tmo_at = 0; gnt_seen = 0;
        for (int n = 1; n <= 20; n++) begin
            tick();
            if (wr_done) n_wr++;
            if (tmo_at != 0 && gnt != 0) gnt_seen = 1;
            if (timeout_err && tmo_at == 0) tmo_at = n;
        end
        chk("tmo_edge", 32'(tmo_at), 32'd10);
        chk("tmo_writes", 32'(n_wr), 32'd1);
        chk("tmo_blocked_no_gnt", 32'(gnt_seen), 32'd0);
        chk("tmo_idle", 32'(busy), 32'd0);
        req = 4'h0; tick();
        req = 4'h8; tick();
        chk("tmo_regrant", 32'(gnt), 32'h8);
        chk("tmo_sticky", 32'(timeout_err), 32'd1);
`else
        // Held-high req writes once and RELEASE waits indefinitely.
        reset = 1'b1; req = 4'h0; tick();
        reset = 1'b0; req = 4'h1; wdata = 16'h000C; n_wr = 0;
        for (int n = 0; n < 15; n++) begin
            tick();
            if (wr_done) n_wr++;
        end
        chk("hold_writes", 32'(n_wr), 32'd1);
        chk("hold_busy", 32'(busy), 32'd1);
        chk("hold_q", 32'(q), 32'hC);
        req = 4'h0; tick();
        chk("hold_release_busy", 32'(busy), 32'd0);
`endif

        // Randomized traffic against the model.
        reset = 1'b1; req = 4'h0;
        tick();
        model_step(1'b1, 4'h0, 16'h0);
        for (int c = 0; c < 1500; c++) begin
            r = ($urandom_range(0, 99) == 0);
            for (int i = 0; i < N; i++) begin
                if (req[i]) begin
                    if ($urandom_range(0, 2) == 0) req[i] = 1'b0;
                end else if ($urandom_range(0, 3) == 0) begin
                    req[i] = 1'b1;
                end
            end
            reset = r;
            wdata = 16'($urandom);
            tick();
            model_step(r, req, wdata);
            chk($sformatf("rand%0d{gnt,q,wr,win,busy}", c), 32'(outs()),
                32'({m_gnt, m_q, m_wr, 2'(m_win), m_busy}));
`ifdef ARB_TIMEOUT_EN
            chk($sformatf("rand%0d_timeout_err", c), 32'(timeout_err), 32'(m_err));
`endif
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/rr_reg_arbiter.md
Name: rr_reg_arbiter

Overview:
- Round-robin arbiter that shares one WIDTH-bit storage register among NREQ requesters.
- Each requester raises req with its write data. The arbiter grants one requester at a time, commits its data to the register and waits for the requester to release.
- Sits in front of the team's 4-bit register datapath. Provides registered q, a one-cycle write-done pulse and the winner index.

Parameters:
- NREQ, 4, number of requesters (2..8)
- WIDTH, 4, data/register width
- IDXW, $clog2(NREQ), winner index width (derived; not overridden)

Ports:
- clk  in  1  single clock, rising edge
- reset  in  1  synchronous, active-high; sampled only on posedge clk
- req  in  NREQ  per-requester write request, level
- wdata  in  NREQ*WIDTH  requester i data in bits [i*WIDTH +: WIDTH]
- gnt  out  NREQ  one-hot grant, registered
- q  out  WIDTH  shared register contents
- wr_done  out  1  one-cycle pulse: q updated this cycle
- winner  out  IDXW  index of last granted requester
- busy  out  1  high whenever state != IDLE
- timeout_err  out  1  sticky error; port exists only with ARB_TIMEOUT_EN

Behaviour:
- Reset (posedge clk while reset=1): state=IDLE, gnt=0, q=0, wr_done=0, winner=0, busy=0, rr pointer=NREQ-1 so requester 0 has first priority, timeout_err=0. Reset overrides every other event, including mid-GRANT or mid-RELEASE; an in-flight write is dropped and q returns to 0.
- States: IDLE, GRANT, RELEASE.
- IDLE, any req bit high:
  - Choose the first set req scanning upward from (ptr+1) mod NREQ, wrapping.
  - Next cycle: gnt=onehot(choice), winner=choice, state=GRANT.
- IDLE, no req: stay; gnt=0.
- GRANT, req[winner] still 1 at the edge:
  - q <= wdata[winner]; wr_done=1 for exactly the next cycle.
  - ptr <= winner; gnt <= 0; state=RELEASE.
- GRANT, req[winner]=0 at the edge (abort): no write, wr_done stays 0, ptr unchanged, gnt <= 0, state=IDLE.
- RELEASE: stay until req[winner]=0, then state=IDLE. Each requester gets exactly one write per req assertion; a held-high req never double-writes.
- Latency: req high sampled at edge N -> gnt high after N -> q and wr_done valid after edge N+1. Minimum 3 cycles per transaction (IDLE, GRANT, RELEASE) when the requester drops req on the cycle after wr_done.
- Simultaneous requests: served strictly round-robin; the last winner has lowest priority next time.
- Other requesters' req changes during GRANT or RELEASE are ignored until IDLE.
- wdata of non-winners is don't-care. Widths are exact; no arithmetic beyond the mod-NREQ pointer wrap.
- busy = (state != IDLE), registered with the state.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - 4-bit counter runs in RELEASE. If req[winner] is still high after 8 RELEASE cycles, force state=IDLE and set timeout_err=1.
  - timeout_err is sticky until reset.
  - The forced requester cannot be re-granted until its req has been seen low once; a per-requester block mask clears on req low.
- Undefined: no counter, no mask, no timeout_err port; RELEASE waits indefinitely.

Decomposition:
- Package rr_reg_arbiter_pkg:
  - state enum type (IDLE, GRANT, RELEASE)
  - NREQ_MAX=8
  - TIMEOUT_CYCLES=8
  - reset pointer constant
- One sub-module, rr_pick: combinational rotate-priority encoder. Inputs: req vector, ptr. Outputs: found flag, index.
- The state machine, q register and timeout logic stay in the top.

Test Plan:
1. Reset held 2 cycles with req=4'b1111 -> gnt=0, q=0, busy=0, wr_done=0 throughout reset.
2. req[2]=1, wdata[2]=4'hA, dropped after wr_done -> gnt=4'b0100 one cycle later; q=4'hA with wr_done pulse the following cycle; winner=2; back to IDLE.
3. req=4'b1111 held, each bit dropped after its wr_done, data i=4'h1..4'h4 -> grant order 0,1,2,3; final q=4'h4; exactly 4 wr_done pulses.
4. req[1] dropped during GRANT -> no wr_done, q unchanged, next contention req=4'b0011 still grants 1 before 0 (ptr unchanged).
5. Reset asserted during GRANT with wdata=4'h7 -> q=0, gnt=0, state IDLE; no wr_done.
6. (ARB_TIMEOUT_EN) req[3] held high permanently -> after 8 RELEASE cycles timeout_err=1, state IDLE; requester 3 not re-granted until req[3] toggles low.
